// File: rtl/elastic_pipe_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register: the per-stage update
// decode and the occupancy counter width.
package elastic_pipe_reg_pkg;

    // What a single stage does on the coming clock edge.
    typedef enum logic [1:0] {
        StHold   = 2'd0,
        StLoad   = 2'd1,
        StBubble = 2'd2,
        StClear  = 2'd3
    } stage_op_e;

    // Flush beats everything. An advancing stage copies a bubble without touching
    // its data, which keeps the data registers quiet when nothing useful arrives.
    function automatic stage_op_e stage_op(input logic flush, input logic adv,
                                           input logic src_valid);
        if (flush) begin
            return StClear;
        end
        if (!adv) begin
            return StHold;
        end
        return src_valid ? StLoad : StBubble;
    endfunction

    // Bits needed to count 0..depth set valid flags.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_reg_pipe_stage.sv
// One stage of the elastic pipeline: a WIDTH-bit data register plus its valid flag.
// The advance decision is made by the parent; this stage only applies it.
module elastic_pipe_reg_pipe_stage
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             adv_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    stage_op_e        op;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        op      = stage_op(flush_i, adv_i, src_valid_i);
        valid_d = valid_q;
        data_d  = data_q;
        unique case (op)
            StHold: begin
            end
            StLoad: begin
                valid_d = 1'b1;
                data_d  = src_data_i;
            end
            StBubble: begin
                valid_d = 1'b0;
            end
            StClear: begin
                valid_d = 1'b0;
                if (CLEAR_DATA) begin
                    data_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-stage elastic pipeline register with ready/valid handshake, global stall and
// synchronous flush. Empty stages absorb data even while later stages are blocked.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 2,
    parameter bit          CLEAR_DATA = 1'b0,
    localparam int unsigned OccW      = occ_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [OccW-1:0]  occupancy_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "elastic_pipe_reg: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_vec [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             freeze;
    logic [OccW-1:0]  occ;

    assign freeze = stall_i | flush_i;

    // Ready ripples backwards: a stage may advance if it is empty or its successor advances.
    always_comb begin
        adv = '0;
        if (!freeze) begin
            adv[DEPTH-1] = out_ready_i | ~valid_vec[DEPTH-1];
            for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
                adv[k] = adv[k+1] | ~valid_vec[k];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ = occ + OccW'(valid_vec[k]);
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = in_valid_i;
            assign src_data  = in_data_i;
        end else begin : g_body
            assign src_valid = valid_vec[k-1];
            assign src_data  = data_vec[k-1];
        end

        elastic_pipe_reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk_i       (clk_i),
            .reset_ni    (reset_ni),
            .flush_i     (flush_i),
            .adv_i       (adv[k]),
            .src_valid_i (src_valid),
            .src_data_i  (src_data),
            .valid_o     (valid_vec[k]),
            .data_o      (data_vec[k])
        );
    end

    assign in_ready_o  = adv[0];
    assign out_valid_o = valid_vec[DEPTH-1];
    assign out_data_o  = data_vec[DEPTH-1];
    assign occupancy_o = occ;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: two configurations driven in lockstep, each checked against
// a slot-level beat model, plus directed checks of streaming, backpressure, stall and flush.
module tb_elastic_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        d2_in_ready, d2_out_valid;
    logic [31:0] d2_out_data;
    logic [1:0]  d2_occ;
    logic        d3_in_ready, d3_out_valid;
    logic [31:0] d3_out_data;
    logic [1:0]  d3_occ;

    int n_cmp;
    int n_err;

    // Reference model: slot contents per instance (0: DEPTH=2 clearing, 1: DEPTH=3 keeping).
    logic        mv  [2][4];
    logic [31:0] md  [2][4];
    int          dep [2];
    bit          clr [2];

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .CLEAR_DATA(1'b1)) u_d2 (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .stall_i     (stall),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (d2_in_ready),
        .out_valid_o (d2_out_valid),
        .out_data_o  (d2_out_data),
        .out_ready_i (out_ready),
        .occupancy_o (d2_occ)
    );

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(3), .CLEAR_DATA(1'b0)) u_d3 (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .stall_i     (stall),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (d3_in_ready),
        .out_valid_o (d3_out_valid),
        .out_data_o  (d3_out_data),
        .out_ready_i (out_ready),
        .occupancy_o (d3_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_occ(input int i);
        int c;
        c = 0;
        for (int k = 0; k < dep[i]; k++) begin
            c += int'(mv[i][k]);
        end
        return c;
    endfunction

    // Room exists when any slot is free, or the head beat is leaving right now.
    function automatic logic m_rdy(input int i);
        return !stall && !flush && ((m_occ(i) < dep[i]) || out_ready);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                mv[i][k] = 1'b0;
                md[i][k] = '0;
            end
        end
    endtask

    // Beats move forward at most one slot per edge, filling any hole ahead of them.
    task automatic m_step();
        int d;
        if (!rst_n) return;
        for (int i = 0; i < 2; i++) begin
            d = dep[i];
            if (flush) begin
                for (int k = 0; k < d; k++) begin
                    mv[i][k] = 1'b0;
                    if (clr[i]) md[i][k] = '0;
                end
            end else if (!stall) begin
                if (mv[i][d-1] && out_ready) mv[i][d-1] = 1'b0;
                for (int k = d - 1; k >= 1; k--) begin
                    if (!mv[i][k] && mv[i][k-1]) begin
                        mv[i][k]   = 1'b1;
                        md[i][k]   = md[i][k-1];
                        mv[i][k-1] = 1'b0;
                    end
                end
                if (!mv[i][0] && in_valid) begin
                    mv[i][0] = 1'b1;
                    md[i][0] = in_data;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("d2.in_ready",  32'(d2_in_ready),  32'(m_rdy(0)));
        chk("d2.out_valid", 32'(d2_out_valid), 32'(mv[0][1]));
        chk("d2.out_data",  d2_out_data,       md[0][1]);
        chk("d2.occupancy", 32'(d2_occ),       32'(m_occ(0)));
        chk("d3.in_ready",  32'(d3_in_ready),  32'(m_rdy(1)));
        chk("d3.out_valid", 32'(d3_out_valid), 32'(mv[1][2]));
        chk("d3.out_data",  d3_out_data,       md[1][2]);
        chk("d3.occupancy", 32'(d3_occ),       32'(m_occ(1)));
    endtask

    // Inputs change at posedge+1; outputs are compared at the negedge before each edge.
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        m_step();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        dep[0] = 2; clr[0] = 1'b1;
        dep[1] = 3; clr[1] = 1'b0;
        m_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset.d2_occ", 32'(d2_occ), 32'd0);
        chk("reset.d2_in_ready", 32'(d2_in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Streaming 1,2,3 through DEPTH=2 with the sink always ready.
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 3);
            in_data  = 32'(t + 1);
            tick();
            if (t >= 1 && t <= 3) begin
                chk("stream.valid", 32'(d2_out_valid), 32'd1);
                chk("stream.data", d2_out_data, 32'(t));
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: A and B fill DEPTH=2, C waits until the sink opens.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        in_data = 32'hC;
        #1;
        chk("bp.occ_full", 32'(d2_occ), 32'd2);
        chk("bp.in_ready_full", 32'(d2_in_ready), 32'd0);
        tick();
        chk("bp.hold_data", d2_out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("bp.ready_passthru", 32'(d2_in_ready), 32'd1);
        tick();
        chk("bp.after_pop", d2_out_data, 32'hB);
        chk("bp.c_accepted", 32'(d2_occ), 32'd2);
        in_valid = 1'b0;
        tick();
        chk("bp.c_out", d2_out_data, 32'hC);
        repeat (4) tick();

        // Bubble collapse: stage1 full, stage0 empty, sink blocked.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bubble.occ1", 32'(d2_occ), 32'd1);
        in_valid = 1'b1; in_data = 32'h5;
        #1;
        chk("bubble.in_ready", 32'(d2_in_ready), 32'd1);
        tick();
        chk("bubble.occ2", 32'(d2_occ), 32'd2);

        // Stall freezes everything for three cycles.
        stall = 1'b1; in_data = 32'h9;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("stall.occ", 32'(d2_occ), 32'd2);
            chk("stall.in_ready", 32'(d2_in_ready), 32'd0);
            chk("stall.data", d2_out_data, 32'h44);
        end

        // Flush wins over stall and drops the presented beat.
        flush = 1'b1;
        tick();
        chk("flush.occ", 32'(d2_occ), 32'd0);
        chk("flush.valid", 32'(d2_out_valid), 32'd0);
        chk("flush.data_cleared", d2_out_data, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Random traffic against the model.
        for (int t = 0; t < 400; t++) begin
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            tick();
        end

        // Asynchronous reset with beats in flight.
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_data = 32'h100 + 32'(t);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.d3_valid", 32'(d3_out_valid), 32'd0);
        chk("areset.d3_occ", 32'(d3_occ), 32'd0);
        chk("areset.d3_data", d3_out_data, 32'd0);
        chk("areset.d2_data", d2_out_data, 32'd0);
        m_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 60; t++) begin
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_data   = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
